// File: rtl/data_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_initiator
// Brief    : MEM-stage load/store initiator with programmable wait states and
//            a registered valid/ready response. Defining
//            DATA_MEM_INIT_BOUNDS_CHECK_EN enables the bounds/alignment checker.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_initiator #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] data,
    input  logic [31:0] mem_result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_nxt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_legal;
    logic        w_access;
    logic        w_last;

`ifdef DATA_MEM_INIT_BOUNDS_CHECK_EN
    // 33-bit end address so a window touching the top of the map cannot wrap
    localparam logic [32:0] c_END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    assign w_legal = (req_addr[1:0] == 2'b00)
                   && (req_addr >= BASE_ADDR)
                   && ({1'b0, req_addr} < c_END_ADDR);
`else
    assign w_legal = 1'b1;
`endif

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_access = (r_state == S_ACCESS);
    assign w_last   = (r_wcnt == c_WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            S_IDLE: begin
                w_wcnt_nxt = 4'd0;
                if (w_accept) begin
                    w_state_nxt = w_legal ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                w_wcnt_nxt = r_wcnt + 4'd1;
                if (w_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rdata <= 32'd0;
                r_err   <= ~w_legal;
            end else if (w_access && w_last && !r_write) begin
                r_rdata <= mem_result;
            end
        end
    end

    // Stores write only in the last ACCESS cycle so each request gives one pulse
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_read   = w_access && !r_write;
    assign mem_write  = w_access && r_write && w_last;
    assign address    = w_access ? r_addr  : 32'd0;
    assign data       = w_access ? r_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_initiator
// Brief    : Three initiators (WAIT_CYCLES 0, 2, 3), each with a memory and a
//            transaction-level reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_initiator;

    localparam logic [31:0] BASE  = 32'd1024;
    localparam int          DEPTH = 64;
    localparam int          NENV  = 3;
`ifdef DATA_MEM_INIT_BOUNDS_CHECK_EN
    localparam bit CHK  = 1'b1;
    localparam int NDIR = 10;
`else
    localparam bit CHK  = 1'b0;
    localparam int NDIR = 6;
`endif

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          hold;
        logic        rst;
    } dir_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic check(input string name, input int w, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL W=%0d %s: got %0h required %0h at %0t", w, name, act, exp, $time);
        end
    endtask

    task automatic mark_done();
        n_done++;
    endtask

    function automatic int widx(input logic [31:0] a);
        if (a < BASE || a >= BASE + 32'(4 * DEPTH)) return -1;
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h0BAD_F00D;
            1:       return 32'hDEAD_BEEF;
            2:       return 32'h2222_2222;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return BASE - 32'd4;
            1:       return BASE + 32'(4 * DEPTH);
            2:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
            3:       return $urandom;
            4:       return BASE + 32'(4 * (DEPTH - 1));
            default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    function automatic dir_t dir_entry(input int i);
        dir_t d;
        d.wr = 1'b0; d.addr = 32'd0; d.wdata = 32'd0; d.rdata = 32'd0;
        d.err = 1'b0; d.hold = 0; d.rst = 1'b0;
        case (i)
            0: begin d.addr = 32'd1028; d.rdata = 32'hDEAD_BEEF; end
            1: begin d.wr = 1'b1; d.addr = 32'd1276; d.wdata = 32'h1234_5678; end
            2: begin d.addr = 32'd1276; d.rdata = 32'h1234_5678; d.hold = 4; end
            3: begin d.addr = 32'd1024; d.rdata = 32'h0BAD_F00D; end
            4: begin d.wr = 1'b1; d.addr = 32'd1032; d.wdata = 32'hCAFE_F00D; d.rst = 1'b1; end
            5: begin d.addr = 32'd1032; d.rdata = 32'h2222_2222; end
            6: begin d.addr = 32'd1022; d.err = 1'b1; end
            7: begin d.wr = 1'b1; d.addr = 32'd1020; d.wdata = 32'hFFFF_FFFF; d.err = 1'b1; end
            8: begin d.addr = 32'd1280; d.err = 1'b1; end
            default: begin d.addr = 32'd1028; d.rdata = 32'hDEAD_BEEF; end
        endcase
        return d;
    endfunction

    for (genvar gi = 0; gi < NENV; gi++) begin : g_env
        localparam int W = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;

        logic        rst_n, req_valid, req_write, req_ready, resp_valid, resp_ready;
        logic        resp_err, mem_read, mem_write;
        logic [31:0] req_addr, req_wdata, resp_rdata, address, data, mem_result;
        logic [31:0] mem [DEPTH];

        data_mem_initiator #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (DEPTH),
            .WAIT_CYCLES (W)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid),
            .req_write  (req_write),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .req_ready  (req_ready),
            .resp_valid (resp_valid),
            .resp_ready (resp_ready),
            .resp_rdata (resp_rdata),
            .resp_err   (resp_err),
            .mem_read   (mem_read),
            .mem_write  (mem_write),
            .address    (address),
            .data       (data),
            .mem_result (mem_result)
        );

        // Target memory: combinational read, write at the clock edge
        assign mem_result = (widx(address) >= 0) ? mem[6'(widx(address))] : 32'h0;

        initial begin
            for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
            forever begin
                @(posedge clk);
                if (mem_write && widx(address) >= 0) mem[6'(widx(address))] <= data;
            end
        end

        // Reference model: an accepted request becomes a list of expected
        // ACCESS cycles followed by one pending response.
        acc_t        q[$];
        logic [31:0] ref_mem [DEPTH];
        logic        m_resp, m_err;
        logic [31:0] m_rdata;

        initial begin
            acc_t a;
            logic legal;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
            m_resp = 1'b0; m_err = 1'b0; m_rdata = 32'h0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    check("reset_outputs", W,
                          {27'b0, req_ready, resp_valid, resp_err, mem_read, mem_write,
                           resp_rdata, address, data},
                          {27'b0, 1'b1, 4'b0, 96'b0});
                    q.delete();
                    m_resp = 1'b0;
                end else begin
                    a = (q.size() > 0) ? q[0] : '0;
                    check("cycle_outputs", W,
                          {60'b0, req_ready, resp_valid, mem_read, mem_write, address, data},
                          {60'b0, (q.size() == 0 && !m_resp), (q.size() == 0 && m_resp),
                           a.rd, a.wr, a.addr, a.data});
                    if (q.size() == 0 && m_resp)
                        check("resp_payload", W, {95'b0, resp_err, resp_rdata},
                              {95'b0, m_err, m_rdata});
                    if (q.size() > 0) begin
                        a = q.pop_front();
                        if (a.wr && widx(a.addr) >= 0) ref_mem[6'(widx(a.addr))] = a.data;
                    end else if (m_resp) begin
                        if (resp_ready) m_resp = 1'b0;
                    end else if (req_valid) begin
                        legal = !CHK || (req_addr[1:0] == 2'b00 && req_addr >= BASE
                                         && req_addr < BASE + 32'(4 * DEPTH));
                        m_resp = 1'b1;
                        if (legal) begin
                            for (int i = 0; i <= W; i++)
                                q.push_back('{rd: !req_write, wr: req_write && (i == W),
                                              addr: req_addr, data: req_wdata});
                            m_err   = 1'b0;
                            m_rdata = (req_write || widx(req_addr) < 0) ? 32'h0
                                      : ref_mem[6'(widx(req_addr))];
                        end else begin
                            m_err   = 1'b1;
                            m_rdata = 32'h0;
                        end
                    end
                end
            end
        end

        initial begin
            dir_t d;
            logic acc, got, first, hs;
            int   n, lat, rdc, wrc, h, exp_rd, exp_wr;
            rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
            req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
            @(posedge clk); #1;

            for (int e = 0; e < NDIR; e++) begin
                d = dir_entry(e);
                req_valid = 1'b1; req_write = d.wr; req_addr = d.addr; req_wdata = d.wdata;
                resp_ready = (d.hold == 0);
                acc = 1'b0; n = 0;
                while (!acc && n < 50) begin
                    @(negedge clk);
                    acc = req_ready;
                    n++;
                    if (!acc) begin @(posedge clk); #1; end
                end
                check("accept_in_first_idle", W, 128'({acc, n == 1}), 128'(2'b11));
                @(posedge clk); #1;
                req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;

                if (d.rst) begin
                    if (W >= 1) begin @(posedge clk); #1; end
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("reset_mid_store", W, 128'({req_ready, mem_write, address}),
                          128'({1'b1, 1'b0, 32'h0}));
                    @(posedge clk); #2;
                    rst_n = 1'b1;
                    @(posedge clk); #1;
                end else begin
                    lat = 1; rdc = 0; wrc = 0; h = 0; got = 1'b0; first = 1'b1; n = 0;
                    exp_rd = (!d.err && !d.wr) ? W + 1 : 0;
                    exp_wr = (!d.err && d.wr) ? 1 : 0;
                    while (!got && n < 100) begin
                        @(negedge clk);
                        n++;
                        if (resp_valid) begin
                            if (first) begin
                                first = 1'b0;
                                check("latency", W, 128'(lat), 128'(d.err ? 1 : W + 2));
                                check("resp_data", W, 128'({d.err, d.rdata}) ^ 128'(0)
                                      ^ 128'({resp_err, resp_rdata}) ^ 128'({d.err, d.rdata}),
                                      128'({d.err, d.rdata}));
                                check("mem_pulses", W, 128'({rdc, wrc}), 128'({exp_rd, exp_wr}));
                            end
                            if (resp_ready) got = 1'b1;
                            else h++;
                        end else begin
                            lat++;
                            rdc += int'(mem_read);
                            wrc += int'(mem_write);
                        end
                        @(posedge clk); #1;
                        if (h >= d.hold) resp_ready = 1'b1;
                    end
                    check("resp_handshake", W, 128'(got), 128'(1));
                end
            end

            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                hs = req_valid && req_ready;
                @(posedge clk); #1;
                if (hs || !req_valid) begin
                    req_valid = ($urandom_range(0, 3) != 0);
                    req_write = 1'($urandom_range(0, 1));
                    req_addr  = rand_addr();
                    req_wdata = $urandom;
                end
                resp_ready = ($urandom_range(0, 2) != 0);
            end
            req_valid = 1'b0;
            repeat (W + 4) @(posedge clk);
            mark_done();
        end
    end

    initial begin
        int t;
        t = 0;
        while (n_done < NENV && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (n_done < NENV) begin
            n_chk++;
            n_fail++;
            $display("FAIL watchdog: %0d environments finished, required %0d", n_done, NENV);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_initiator.md
# data_mem_initiator

Initiator side of the data-memory port: accepts one load/store request at a time from the MEM pipeline stage and drives the data memory's `mem_read`, `mem_write`, `address` and `data` pins. It samples `mem_result` back and returns a registered response through a valid/ready handshake. Programmable wait states emulate slower memory, and an optional bounds/alignment checker blocks illegal accesses before they reach the array. It sits between the MEM stage and the data memory.

## Interface
- `BASE_ADDR`, 1024, byte address of memory word 0
- `DEPTH_WORDS`, 64, number of 32-bit words in the target memory
- `WAIT_CYCLES`, 0, extra ACCESS cycles per request; legal range 0..15
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- `req_valid`  in  1  pipeline request present
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data
- `req_ready`  out  1  controller can accept a request (IDLE)
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  pipeline consumes response
- `resp_rdata`  out  32  load data (0 for stores and errors)
- `resp_err`  out  1  request rejected (bounds/alignment)
- `mem_read`  out  1  to memory read enable
- `mem_write`  out  1  to memory write enable
- `address`  out  32  to memory byte address
- `data`  out  32  to memory write data
- `mem_result`  in  32  from memory, combinational read data

## Operation
- FSM states are IDLE, ACCESS and RESP. The 4-bit wait counter `wcnt` is cleared in IDLE.
- IDLE:
  - `req_ready` is 1.
  - On `req_valid & req_ready`, latch write/addr/wdata.
  - A legal request goes to ACCESS with `wcnt` = 0.
  - An illegal request goes to RESP with `resp_err` = 1 and `resp_rdata` = 0. An illegal request never drives the memory.
- ACCESS:
  - `address` and `data` are driven from the latches.
  - A load holds `mem_read` = 1 in every ACCESS cycle.
  - A store asserts `mem_write` = 1 only in the final ACCESS cycle (`wcnt == WAIT_CYCLES`), giving exactly one write pulse.
  - `wcnt` increments every cycle. In the final cycle, a load captures `mem_result` into `resp_rdata`, and the FSM goes to RESP.
- RESP:
  - `resp_valid` is 1, and `resp_rdata` and `resp_err` are stable.
  - On `resp_ready`, return to IDLE. If `resp_ready` is 0, hold indefinitely.
- Outside ACCESS, `mem_read`, `mem_write`, `address` and `data` are all 0.
- Address legality:
  - `req_addr[1:0]` must be 00.
  - `BASE_ADDR <= req_addr < BASE_ADDR + 4*DEPTH_WORDS`.
  - Compare as 32-bit unsigned. There is no wrap-around: addresses below base are illegal.
- `req_valid` during ACCESS or RESP is ignored. `req_ready` is 0 in those states, and the pipeline holds the request.

## Timing
- Reset values:
  - The state is IDLE, so `req_ready` is 1.
  - `resp_valid`, `resp_err`, `mem_read` and `mem_write` are 0.
  - `resp_rdata`, `address` and `data` are 0.
  - `wcnt` is 0.
- Legal request accepted at edge k:
  - ACCESS occupies cycles k+1 .. k+1+WAIT_CYCLES.
  - `resp_valid` rises after edge k+2+WAIT_CYCLES.
  - With WAIT_CYCLES = 0, the request-to-response latency is 2 cycles.
- Illegal request accepted at edge k: `resp_valid` rises after edge k+1.
- Back-to-back throughput: `resp_ready` = 1 in the RESP cycle returns to IDLE at the next edge, and a new request can be accepted in that IDLE cycle.
- The store write commits at the edge ending the final ACCESS cycle, which is the memory's synchronous write. A load issued right after sees the new data.
- Reset asserted mid-operation:
  - Immediate return to IDLE and all outputs go to reset values.
  - A store reset before its final ACCESS cycle is never written.
  - A pending response is discarded.

## Configuration
- `DATA_MEM_INIT_BOUNDS_CHECK_EN` defined: the legality check is active, as in Operation.
- Not defined:
  - Every request goes to ACCESS and `resp_err` is constant 0.
  - `address` passes through unchecked, and range/alignment responsibility lies with the memory.

## Test plan
- Reset, then load at 1028 (WAIT_CYCLES = 0) with word 1 preloaded to 0xDEADBEEF:
  - `mem_read` is high for 1 cycle with `address` = 1028.
  - `resp_valid` comes 2 cycles after accept with `resp_rdata` = 0xDEADBEEF and `resp_err` = 0.
- Store 0x12345678 to 1276, then load from 1276:
  - `mem_write` pulses for exactly 1 cycle.
  - The load returns 0x12345678.
  - The store response has `resp_rdata` = 0.
- WAIT_CYCLES = 3, load at 1024:
  - `mem_read` is high for 4 consecutive cycles.
  - `resp_valid` comes 5 cycles after accept.
  - `req_ready` stays 0 throughout.
- With the macro defined, requests to 1022 (misaligned), 1020 (below base) and 1280 (past end):
  - Each gets `resp_err` = 1 after 1 cycle.
  - `mem_read` and `mem_write` never assert.
- Hold `resp_ready` = 0 for 4 cycles in RESP:
  - `resp_valid` and `resp_rdata` stay stable and no new request is accepted.
  - Raising `resp_ready` lets the next request be accepted in the following cycle.
- Store with WAIT_CYCLES = 2, `rst_n` pulsed low in the 2nd ACCESS cycle:
  - The FSM returns to IDLE and the outputs go to 0.
  - A subsequent load of that address returns the old value.
